// File: rtl/cmos_cam_pkg.sv
// rtl/cmos_cam_pkg.sv - shared types and constants for the SCCB camera configurator
package cmos_cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAM_RST,
    ST_SETTLE,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } cam_state_e;

  localparam logic [7:0] DEFAULT_DEV_ID = 8'h42;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cam_entry_t;

endpackage

// File: rtl/cmos_cam_reg_rom.sv
// rtl/cmos_cam_reg_rom.sv - combinational camera register table, {reg, data} per entry
module cmos_cam_reg_rom
  import cmos_cam_pkg::*;
(
  input  logic [7:0] index_i,
  output cam_entry_t entry_o
);

  // Entries past the populated range read back as the 0xFF/0xFF end marker.
  always_comb begin
    entry_o = '{reg_addr: 8'hFF, data: 8'hFF};
    case (index_i)
      8'd0:  entry_o = '{reg_addr: 8'h12, data: 8'h80};
      8'd1:  entry_o = '{reg_addr: 8'h11, data: 8'h01};
      8'd2:  entry_o = '{reg_addr: 8'h3A, data: 8'h04};
      8'd3:  entry_o = '{reg_addr: 8'h12, data: 8'h00};
      8'd4:  entry_o = '{reg_addr: 8'h17, data: 8'h13};
      8'd5:  entry_o = '{reg_addr: 8'h18, data: 8'h01};
      8'd6:  entry_o = '{reg_addr: 8'h32, data: 8'hB6};
      8'd7:  entry_o = '{reg_addr: 8'h19, data: 8'h02};
      8'd8:  entry_o = '{reg_addr: 8'h1A, data: 8'h7A};
      8'd9:  entry_o = '{reg_addr: 8'h03, data: 8'h0A};
      8'd10: entry_o = '{reg_addr: 8'h0C, data: 8'h00};
      8'd11: entry_o = '{reg_addr: 8'h3E, data: 8'h00};
      8'd12: entry_o = '{reg_addr: 8'h70, data: 8'h3A};
      8'd13: entry_o = '{reg_addr: 8'h71, data: 8'h35};
      8'd14: entry_o = '{reg_addr: 8'h72, data: 8'h11};
      8'd15: entry_o = '{reg_addr: 8'h73, data: 8'hF0};
      default: entry_o = '{reg_addr: 8'hFF, data: 8'hFF};
    endcase
  end

endmodule

// File: rtl/cmos_cam_config.sv
// rtl/cmos_cam_config.sv - camera reset/settle then SCCB write of every table entry
module cmos_cam_config
  import cmos_cam_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 25,
  parameter logic [7:0]  DEV_ID        = DEFAULT_DEV_ID,
  parameter int unsigned TABLE_LEN     = 64,
  parameter int unsigned RST_CYCLES    = 1000,
  parameter int unsigned SETTLE_CYCLES = 100000,
  parameter int unsigned GAP_TICKS     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_start,
  output logic       io_busy,
  output logic       io_done,
  output logic [7:0] io_index,
  output logic       io_sccbClock,
  output logic       io_sccbData,
  output logic       io_camResetN,
  output logic       io_camPowerDown
);

  localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_TICKS - 1);
  localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [8:0]  TABLE_END   = 9'(TABLE_LEN);

  cam_state_e  state_q, state_d;
  logic [31:0] dly_q, dly_d;
  logic [15:0] div_q, div_d;
  logic [15:0] step_q, step_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [8:0]  index_q, index_d;
  cam_entry_t  entry_q, entry_d;
  cam_entry_t  rom_entry;
  logic        tick;
  logic        bus_active;
  logic [7:0]  cur_byte;
  logic        cur_bit;

  cmos_cam_reg_rom u_rom (
    .index_i (index_q[7:0]),
    .entry_o (rom_entry)
  );

  assign bus_active = (state_q == ST_START) || (state_q == ST_BITS) ||
                      (state_q == ST_STOP)  || (state_q == ST_GAP);
  assign tick       = bus_active && (div_q == DIV_LAST);

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = DEV_ID;
      2'd1:    cur_byte = entry_q.reg_addr;
      default: cur_byte = entry_q.data;
    endcase
  end

  // bit_q == 8 is the ninth (don't-care) bit, always driven high.
  assign cur_bit = bit_q[3] ? 1'b1 : cur_byte[3'd7 - bit_q[2:0]];

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    div_d   = bus_active ? (tick ? 16'd0 : div_q + 16'd1) : 16'd0;
    step_d  = step_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    index_d = index_q;
    entry_d = entry_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (io_start) begin
          state_d = ST_CAM_RST;
          dly_d   = 32'd0;
          index_d = 9'd0;
        end
      end
      ST_CAM_RST: begin
        if (dly_q == RST_LAST) begin
          state_d = ST_SETTLE;
          dly_d   = 32'd0;
        end else begin
          dly_d = dly_q + 32'd1;
        end
      end
      ST_SETTLE: begin
        if (dly_q == SETTLE_LAST) begin
          state_d = ST_START;
          dly_d   = 32'd0;
          index_d = 9'd0;
          byte_d  = 2'd0;
          bit_d   = 4'd0;
          step_d  = 16'd0;
        end else begin
          dly_d = dly_q + 32'd1;
        end
      end
      ST_START: begin
        if (step_q == 16'd0) entry_d = rom_entry;
        if (tick) begin
          if (step_q == 16'd1) begin
            state_d = ST_BITS;
            step_d  = 16'd0;
            bit_d   = 4'd0;
            byte_d  = 2'd0;
          end else begin
            step_d = step_q + 16'd1;
          end
        end
      end
      ST_BITS: begin
        if (tick) begin
          if (step_q == 16'd3) begin
            step_d = 16'd0;
            if (bit_q == 4'd8) begin
              bit_d = 4'd0;
              if (byte_q == 2'd2) begin
                state_d = ST_STOP;
                byte_d  = 2'd0;
              end else begin
                byte_d = byte_q + 2'd1;
              end
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            step_d = step_q + 16'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (step_q == 16'd2) begin
            state_d = ST_GAP;
            step_d  = 16'd0;
          end else begin
            step_d = step_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (step_q == GAP_LAST) begin
            step_d  = 16'd0;
            index_d = index_q + 9'd1;
            state_d = (index_q + 9'd1 == TABLE_END) ? ST_DONE : ST_START;
          end else begin
            step_d = step_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dly_q   <= 32'd0;
      div_q   <= 16'd0;
      step_q  <= 16'd0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      index_q <= 9'd0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      div_q   <= div_d;
      step_q  <= step_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      index_q <= index_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    io_sccbClock = 1'b1;
    io_sccbData  = 1'b1;
    case (state_q)
      ST_START: begin
        io_sccbClock = (step_q == 16'd0);
        io_sccbData  = 1'b0;
      end
      ST_BITS: begin
        io_sccbClock = (step_q == 16'd1) || (step_q == 16'd2);
        io_sccbData  = cur_bit;
      end
      ST_STOP: begin
        io_sccbClock = (step_q != 16'd0);
        io_sccbData  = (step_q == 16'd2);
      end
      default: begin
        io_sccbClock = 1'b1;
        io_sccbData  = 1'b1;
      end
    endcase
  end

  assign io_busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign io_done         = (state_q == ST_DONE);
  assign io_index        = index_q[7:0];
  assign io_camResetN    = (state_q != ST_CAM_RST);
  assign io_camPowerDown = 1'b0;

endmodule

// File: doc/cmos_cam_config.md
CMOS_CAM_CONFIG -- requirements
Module: cmos_cam_config

Interface
REQ-001 Parameter CLK_DIV, default 25; system clocks per SCCB quarter-bit tick (tick = quarter SIOC period), legal range 2..65535.
REQ-002 Parameter DEV_ID, default 0x42; 8-bit SCCB write ID (7-bit address 0x21, R/W=0).
REQ-003 Parameter TABLE_LEN, default 64; number of {reg,data} entries in the register table, legal range 1..256.
REQ-004 Parameter RST_CYCLES, default 1000; clocks io_camResetN is held low at sequence start.
REQ-005 Parameter SETTLE_CYCLES, default 100000; clocks waited after io_camResetN release before the first write.
REQ-006 Parameter GAP_TICKS, default 4; idle ticks, with SIOC=1 and SIOD=1, after each stop condition.
REQ-007 clock  in  1  system clock; all state updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 io_start  in  1  single-cycle request to run the full configuration sequence.
REQ-010 io_busy  out  1  high from the cycle after an accepted start until DONE is entered.
REQ-011 io_done  out  1  high in DONE; cleared by the next accepted start or by reset.
REQ-012 io_index  out  8  table index currently being written, for debug.
REQ-013 io_sccbClock  out  1  SIOC, push-pull.
REQ-014 io_sccbData  out  1  SIOD, push-pull, output only.
REQ-015 io_camResetN  out  1  camera reset, active low.
REQ-016 io_camPowerDown  out  1  camera power-down, constant 0.

Function
REQ-017 FSM states: IDLE, CAM_RST, SETTLE, START, BITS, STOP, GAP, DONE.
REQ-018 IDLE or DONE with io_start=1 -> CAM_RST on the next edge; io_start is ignored in every other state.
REQ-019 CAM_RST drives io_camResetN=0 for exactly RST_CYCLES clocks, then -> SETTLE with io_camResetN=1.
REQ-020 SETTLE counts SETTLE_CYCLES clocks, then -> START with index=0 and byte=0.
REQ-021 The tick counter runs only in START, BITS, STOP and GAP; it issues one tick every CLK_DIV clocks and restarts at 0 on entry to START.
REQ-022 START spans 2 ticks: tick0 SIOC=1, SIOD=0; tick1 SIOC=0, SIOD=0; then -> BITS.
REQ-023 BITS sends 3 bytes in order (DEV_ID, reg, data), MSB first, each followed by a 9th don't-care bit driven as 1.
REQ-024 Each bit spans 4 ticks: q0 SIOC=0 and SIOD=bit; q1 and q2 SIOC=1; q3 SIOC=0; SIOD changes only in q0.
REQ-025 After the 27th bit -> STOP, which spans 3 ticks: (SIOC=0, SIOD=0), (1,0), (1,1); then -> GAP.
REQ-026 GAP holds SIOC=1, SIOD=1 for GAP_TICKS ticks, then increments index; index==TABLE_LEN -> DONE, otherwise -> START.
REQ-027 One complete write takes (2 + 108 + 3 + GAP_TICKS) * CLK_DIV clocks.
REQ-028 The reg/data bytes come from the ROM at the current index and are latched in the first START tick; the ROM is combinational.
REQ-029 Bit counter is 4 bits (0..8), byte counter 2 bits (0..2), index counter 9 bits so TABLE_LEN=256 terminates cleanly.
REQ-030 Outside START, BITS, STOP and CAM_RST the bus idles at SIOC=1, SIOD=1.

Reset
REQ-031 reset=1 on any edge, including mid-byte, forces IDLE, all counters to 0, io_busy=0, io_done=0, io_index=0, io_sccbClock=1, io_sccbData=1, io_camResetN=1 and io_camPowerDown=0 on the following cycle.

Structure
REQ-032 A shared package cmos_cam_pkg holds the FSM state enum, the default DEV_ID, and the table entry type (16 bits: {reg[15:8], data[7:0]}).
REQ-033 The table is the sub-module cmos_cam_reg_rom (input index 8 bits, output entry 16 bits); entry 0 is {0x12, 0x80} (COM7 soft reset).

Verification
REQ-034 CLK_DIV=4, TABLE_LEN=1, ROM[0]={0x12,0x80}, pulse io_start -> sampling SIOD on SIOC rising edges yields 0x42,1,0x12,1,0x80,1; io_done=1 after 1+RST+SETTLE+(113+GAP)*4 clocks.
REQ-035 RST_CYCLES=10, pulse io_start -> io_camResetN=0 for exactly 10 clocks starting one clock after io_start.
REQ-036 TABLE_LEN=3 -> exactly 3 start/stop pairs, io_index steps 0,1,2, io_busy falls in the same cycle io_done rises.
REQ-037 Assert reset during the 2nd byte -> next cycle SIOC=1, SIOD=1, io_busy=0; a later io_start rewrites from index 0.
REQ-038 Pulse io_start while busy -> no effect; pulse io_start in DONE -> io_done clears and the full sequence repeats.
REQ-039 Property check: SIOD never changes while SIOC=1 except in the START tick0 and STOP tick2 transitions.
